// File: rtl/morse_key_timer.sv
// Key front end for the Morse decoder: synchronise and debounce the raw key, time each press as
// dot or dash, and close the letter after an inter-letter silence.
module morse_key_timer #(
  parameter int unsigned DEBOUNCE_CYCLES   = 1000,
  parameter int unsigned DOT_MAX_CYCLES    = 3000,
  parameter int unsigned LETTER_GAP_CYCLES = 6000,
  parameter int unsigned CNT_W             = 24,
  parameter int unsigned MAX_SYMBOLS       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_in,
  output logic       key_level,
  output logic       sym_valid,
  output logic       sym_bit,
  output logic [2:0] sym_count,
  output logic       letter_done,
  output logic       letter_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOT_MAX  = CNT_W'(DOT_MAX_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(LETTER_GAP_CYCLES - 1);
  localparam logic [2:0]       MAX_SYM  = 3'(MAX_SYMBOLS);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic             sync1_q, sync2_q;
  logic             level_q, level_prev_q;
  logic [CNT_W-1:0] deb_cnt_q;
  logic             rise, fall, expire;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d, gap_q, gap_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             ovf_q, ovf_d, bit_q, bit_d, vld_q, vld_d;

  // Level only flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      deb_cnt_q    <= '0;
    end else begin
      sync1_q      <= key_in;
      sync2_q      <= sync1_q;
      level_prev_q <= level_q;
      if (sync2_q == level_q) begin
        deb_cnt_q <= '0;
      end else if (deb_cnt_q == DEB_LAST) begin
        level_q   <= ~level_q;
        deb_cnt_q <= '0;
      end else begin
        deb_cnt_q <= sat_inc(deb_cnt_q);
      end
    end
  end

  assign rise   = level_q & ~level_prev_q;
  assign fall   = ~level_q & level_prev_q;
  assign expire = (state_q == GAP) && (gap_q == GAP_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dur_q   <= '0;
      gap_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      bit_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      gap_q   <= gap_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      bit_q   <= bit_d;
      vld_q   <= vld_d;
    end
  end

  // A rise on the expiry cycle wins the state but the letter still closes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rise) state_d = PRESS;
      PRESS:   if (fall) state_d = GAP;
      GAP: begin
        if (rise)        state_d = PRESS;
        else if (expire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    dur_d = dur_q;
    gap_d = gap_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    bit_d = bit_q;
    vld_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise) begin
          dur_d = CNT_W'(1);
          gap_d = '0;
        end
      end
      PRESS: begin
        if (fall) begin
          gap_d = '0;
          if (cnt_q < MAX_SYM) begin
            vld_d = 1'b1;
            bit_d = (dur_q > DOT_MAX);
            cnt_d = cnt_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          dur_d = sat_inc(dur_q);
        end
      end
      GAP: begin
        gap_d = sat_inc(gap_q);
        if (expire) begin
          gap_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          bit_d = 1'b0;
        end
        if (rise) dur_d = CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    key_level   = level_q;
    sym_valid   = vld_q;
    sym_bit     = bit_q;
    sym_count   = cnt_q;
    letter_done = expire;
    letter_err  = expire & ovf_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_morse_key_timer.sv
// Bench for morse_key_timer: scoreboard of expected symbol/letter strobes, checked every cycle.
module tb_morse_key_timer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_in = 1'b0;
  logic       key_level, sym_valid, sym_bit, letter_done, letter_err, busy;
  logic [2:0] sym_count;

  morse_key_timer #(
    .DEBOUNCE_CYCLES(4), .DOT_MAX_CYCLES(20), .LETTER_GAP_CYCLES(50),
    .CNT_W(24), .MAX_SYMBOLS(5)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_level(key_level),
    .sym_valid(sym_valid), .sym_bit(sym_bit), .sym_count(sym_count),
    .letter_done(letter_done), .letter_err(letter_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_letter;
    bit b;
    int cnt;
    bit err;
    int gap;
    bit busy_after;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   last_sym_cyc = 0;
  int   strobes = 0;
  bit   pend_clear = 0;
  bit   pend_busy = 0;

  function automatic exp_t mk(bit l, bit b, int c, bit e, int g, bit ba);
    exp_t x;
    x.is_letter = l; x.b = b; x.cnt = c; x.err = e; x.gap = g; x.busy_after = ba;
    return x;
  endfunction

  // One clock step; outputs sampled 1 time unit after the edge and matched against the scoreboard.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (pend_clear) begin
      n_cmp++;
      if (sym_count !== 3'd0 || sym_bit !== 1'b0 || busy !== pend_busy) begin
        n_err++;
        $display("FAIL after_letter: cnt=%0d bit=%0b busy=%0b, want cnt=0 bit=0 busy=%0b",
                 sym_count, sym_bit, busy, pend_busy);
      end
      pend_clear = 0;
    end
    if (sym_valid && letter_done) begin
      n_err++;
      $display("FAIL strobe_overlap: sym_valid and letter_done both 1 at cycle %0d", cyc);
    end
    if (letter_err && !letter_done) begin
      n_err++;
      $display("FAIL lone_err: letter_err=1 without letter_done at cycle %0d", cyc);
    end
    if (sym_valid || letter_done) begin
      strobes++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_strobe: sym_valid=%0b letter_done=%0b, want none", sym_valid, letter_done);
      end else begin
        e = sb.pop_front();
        n_cmp++;
        if (letter_done !== e.is_letter || sym_bit !== e.b || sym_count !== 3'(e.cnt) ||
            letter_err !== (e.is_letter & e.err)) begin
          n_err++;
          $display("FAIL sb_event: done=%0b bit=%0b cnt=%0d err=%0b, want done=%0b bit=%0b cnt=%0d err=%0b",
                   letter_done, sym_bit, sym_count, letter_err, e.is_letter, e.b, e.cnt, e.err);
        end
        if (!letter_done) last_sym_cyc = cyc;
        if (letter_done && e.gap >= 0) begin
          n_cmp++;
          if (cyc - last_sym_cyc != e.gap) begin
            n_err++;
            $display("FAIL gap_time: %0d cycles from last symbol, want %0d", cyc - last_sym_cyc, e.gap);
          end
        end
        if (letter_done) begin
          pend_clear = 1;
          pend_busy  = e.busy_after;
        end
      end
    end
  endtask

  task automatic press(int n);
    tick();
    key_in = 1'b1;
    repeat (n) tick();
    key_in = 1'b0;
  endtask

  task automatic idle(int m);
    repeat (m - 1) tick();
  endtask

  task automatic wait_drain(int limit);
    int k = 0;
    while ((sb.size() != 0 || pend_clear) && k < limit) begin
      tick();
      k++;
    end
    n_cmp++;
    if (sb.size() != 0 || pend_clear) begin
      n_err++;
      $display("FAIL drain_timeout: %0d events still pending after %0d cycles, want 0", sb.size(), limit);
      sb.delete();
      pend_clear = 0;
    end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    key_in = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if ({key_level, sym_valid, sym_bit, sym_count, letter_done, letter_err, busy} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_outputs: lvl=%0b v=%0b b=%0b c=%0d d=%0b e=%0b busy=%0b, want all 0",
               key_level, sym_valid, sym_bit, sym_count, letter_done, letter_err, busy);
    end
    rst = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (busy !== 1'b0 || key_level !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: busy=%0b lvl=%0b, want 0 0", busy, key_level);
    end
  endtask

  task automatic test_bounce();
    for (int i = 0; i < 10; i++) begin
      tick();
      key_in = (i % 2 == 0);
      repeat (2) begin
        tick();
        n_cmp++;
        if (key_level !== 1'b0) begin
          n_err++;
          $display("FAIL bounce_glitch: key_level=%0b, want 0", key_level);
        end
      end
    end
    tick();
    key_in = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_cmp++;
      if (key_level !== (i == 6)) begin
        n_err++;
        $display("FAIL bounce_latency: cycle %0d key_level=%0b, want %0b", i, key_level, (i == 6));
      end
    end
    repeat (24) tick();
    key_in = 1'b0;
    sb.push_back(mk(0, 1, 1, 0, -1, 0));
    sb.push_back(mk(1, 1, 1, 0, 49, 0));
    wait_drain(200);
  endtask

  task automatic test_dot_dash();
    press(20);
    sb.push_back(mk(0, 0, 1, 0, -1, 0));
    idle(10);
    press(21);
    sb.push_back(mk(0, 1, 2, 0, -1, 0));
    sb.push_back(mk(1, 1, 2, 0, 49, 0));
    wait_drain(200);
  endtask

  task automatic test_letter_close();
    press(20);
    sb.push_back(mk(0, 0, 1, 0, -1, 0));
    sb.push_back(mk(1, 0, 1, 0, 49, 0));
    wait_drain(200);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 6; i++) begin
      press(5);
      if (i <= 5) sb.push_back(mk(0, 0, i, 0, -1, 0));
      if (i < 6) idle(10);
    end
    sb.push_back(mk(1, 0, 5, 1, -1, 0));
    wait_drain(300);
  endtask

  task automatic test_collision();
    press(10);
    sb.push_back(mk(0, 0, 1, 0, -1, 0));
    sb.push_back(mk(1, 0, 1, 0, 49, 1));
    idle(50);
    press(5);
    sb.push_back(mk(0, 0, 1, 0, -1, 0));
    sb.push_back(mk(1, 0, 1, 0, 49, 0));
    wait_drain(200);
  endtask

  task automatic test_reset_mid_press();
    int k = 0;
    int s0;
    tick();
    key_in = 1'b1;
    while (key_level !== 1'b1 && k < 20) begin
      tick();
      k++;
    end
    n_cmp++;
    if (key_level !== 1'b1) begin
      n_err++;
      $display("FAIL rmp_rise_timeout: key_level=%0b, want 1 within 20 cycles", key_level);
    end
    repeat (15) tick();
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL rmp_busy: busy=%0b, want 1", busy);
    end
    s0 = strobes;
    rst = 1'b1;
    key_in = 1'b0;
    tick();
    n_cmp++;
    if ({key_level, sym_valid, sym_bit, sym_count, letter_done, letter_err, busy} !== 9'd0) begin
      n_err++;
      $display("FAIL rmp_outputs: lvl=%0b v=%0b b=%0b c=%0d d=%0b e=%0b busy=%0b, want all 0",
               key_level, sym_valid, sym_bit, sym_count, letter_done, letter_err, busy);
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (80) tick();
    n_cmp++;
    if (strobes != s0) begin
      n_err++;
      $display("FAIL rmp_no_strobe: %0d strobes after reset, want 0", strobes - s0);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_dot_dash();
    test_letter_close();
    test_overflow();
    test_collision();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
